// File: rtl/hitomezashi_sched.sv
// Hitomezashi pattern scheduler: two Galois LFSRs regenerate v/h stitch starts, committed only on frame.
// Latency: next -> busy next cycle; GEN lasts STEPS cycles; commit visible the cycle after frame in READY.
// No backpressure: next/frame are ignored while busy, never queued. Optional auto-advance: HITOMEZASHI_AUTO_EN.
module hitomezashi_sched #(
    parameter int                 V_LINES     = 30,
    parameter int                 H_LINES     = 17,
    parameter int                 HOLD_FRAMES = 64,
    parameter int                 STEPS       = 47,
    parameter logic [V_LINES-1:0] V_SEED      = 30'h0C0A6A75,
    parameter logic [H_LINES-1:0] H_SEED      = 17'h17436,
    parameter logic [V_LINES-1:0] V_TAPS      = 30'h00000053,
    parameter logic [H_LINES-1:0] H_TAPS      = 17'h04001
) (
    input  logic               i_clk_pix,
    input  logic               i_rst_pix,
    input  logic               i_frame,
    input  logic               i_next,
    input  logic               i_pause,
    output logic [V_LINES-1:0] o_v_start,
    output logic [H_LINES-1:0] o_h_start,
    output logic               o_update,
    output logic               o_busy
);

    localparam int SCW = (STEPS > 0) ? $clog2(STEPS + 1) : 1;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_GEN   = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [V_LINES-1:0] r_v_lfsr;
    logic [H_LINES-1:0] r_h_lfsr;
    logic [V_LINES-1:0] w_v_lfsr_nxt;
    logic [H_LINES-1:0] w_h_lfsr_nxt;
    logic [SCW-1:0]     r_step_cnt;
    logic [SCW-1:0]     w_step_cnt_nxt;
    logic [V_LINES-1:0] r_v_start;
    logic [H_LINES-1:0] r_h_start;
    logic               r_update;
    logic               w_commit;
    logic               w_lfsr_step;

`ifdef HITOMEZASHI_AUTO_EN
    localparam int FCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    logic [FCW-1:0]     r_frame_cnt;
    logic [FCW-1:0]     w_frame_cnt_nxt;
`else
    logic               w_unused_pause;
    assign w_unused_pause = i_pause;
`endif

    // A zeroed register would lock up, so it reloads its seed instead of shifting.
    assign w_v_lfsr_nxt = (r_v_lfsr == '0) ? V_SEED :
                          ({r_v_lfsr[V_LINES-2:0], 1'b0} ^ (r_v_lfsr[V_LINES-1] ? V_TAPS : '0));
    assign w_h_lfsr_nxt = (r_h_lfsr == '0) ? H_SEED :
                          ({r_h_lfsr[H_LINES-2:0], 1'b0} ^ (r_h_lfsr[H_LINES-1] ? H_TAPS : '0));

    always_comb begin
        w_state_nxt     = r_state;
        w_step_cnt_nxt  = r_step_cnt;
        w_commit        = 1'b0;
        w_lfsr_step     = 1'b0;
`ifdef HITOMEZASHI_AUTO_EN
        w_frame_cnt_nxt = r_frame_cnt;
`endif
        case (r_state)
            S_HOLD: begin
                if (i_next) begin
                    w_state_nxt     = S_GEN;
                    w_step_cnt_nxt  = '0;
`ifdef HITOMEZASHI_AUTO_EN
                    w_frame_cnt_nxt = '0;
                end else if (i_frame && !i_pause) begin
                    if (r_frame_cnt == FCW'(HOLD_FRAMES - 1)) begin
                        w_state_nxt     = S_GEN;
                        w_step_cnt_nxt  = '0;
                        w_frame_cnt_nxt = '0;
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + FCW'(1);
                    end
`endif
                end
            end
            S_GEN: begin
                w_lfsr_step    = 1'b1;
                w_step_cnt_nxt = r_step_cnt + SCW'(1);
                if (r_step_cnt == SCW'(STEPS - 1)) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (i_frame) begin
                    w_commit        = 1'b1;
                    w_state_nxt     = S_HOLD;
`ifdef HITOMEZASHI_AUTO_EN
                    w_frame_cnt_nxt = '0;
`endif
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge i_clk_pix) begin
        if (i_rst_pix) begin
            r_state     <= S_HOLD;
            r_v_lfsr    <= V_SEED;
            r_h_lfsr    <= H_SEED;
            r_step_cnt  <= '0;
            r_v_start   <= V_SEED;
            r_h_start   <= H_SEED;
            r_update    <= 1'b0;
`ifdef HITOMEZASHI_AUTO_EN
            r_frame_cnt <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_step_cnt  <= w_step_cnt_nxt;
            r_update    <= w_commit;
`ifdef HITOMEZASHI_AUTO_EN
            r_frame_cnt <= w_frame_cnt_nxt;
`endif
            if (w_lfsr_step) begin
                r_v_lfsr <= w_v_lfsr_nxt;
                r_h_lfsr <= w_h_lfsr_nxt;
            end
            if (w_commit) begin
                r_v_start <= r_v_lfsr;
                r_h_start <= r_h_lfsr;
            end
        end
    end

    assign o_v_start = r_v_start;
    assign o_h_start = r_h_start;
    assign o_update  = r_update;
    assign o_busy    = (r_state != S_HOLD);

endmodule

// File: tb/tb_hitomezashi_sched.sv
// Bench for hitomezashi_sched: directed scenarios plus a randomized run against a pattern-level model.
module tb_hitomezashi_sched;

    localparam int          HF = 4;
    localparam int          ST = 3;
    localparam logic [29:0] VS = 30'h20000000;
    localparam logic [16:0] HS = 17'h10000;
    localparam logic [29:0] VT = 30'h00000053;
    localparam logic [16:0] HT = 17'h04001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame = 1'b0;
    logic        nxt = 1'b0;
    logic        pause = 1'b0;
    logic [29:0] v;
    logic [16:0] h;
    logic        upd;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Model: m_* is the generator sequence, e_* the pattern the renderer should be showing.
    logic [29:0] m_v, e_v;
    logic [16:0] m_h, e_h;

    always #5 clk = ~clk;

    hitomezashi_sched #(
        .V_LINES(30), .H_LINES(17), .HOLD_FRAMES(HF), .STEPS(ST),
        .V_SEED(VS), .H_SEED(HS), .V_TAPS(VT), .H_TAPS(HT)
    ) u_dut (
        .i_clk_pix(clk),
        .i_rst_pix(rst),
        .i_frame(frame),
        .i_next(nxt),
        .i_pause(pause),
        .o_v_start(v),
        .o_h_start(h),
        .o_update(upd),
        .o_busy(busy)
    );

    function automatic logic [29:0] vstep(input logic [29:0] x);
        if (x == 30'h0) return VS;
        return (x << 1) ^ (x[29] ? VT : 30'h0);
    endfunction

    function automatic logic [16:0] hstep(input logic [16:0] x);
        if (x == 17'h0) return HS;
        return (x << 1) ^ (x[16] ? HT : 17'h0);
    endfunction

    task automatic model_reset();
        m_v = VS; m_h = HS; e_v = VS; e_h = HS;
    endtask

    task automatic model_gen();
        for (int i = 0; i < ST; i++) begin
            m_v = vstep(m_v);
            m_h = hstep(m_h);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame = 1'b0; nxt = 1'b0; pause = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
        total++; if (v !== 30'h20000000) begin bad++; $display("FAIL reset_v: got %h want 20000000", v); end
        total++; if (h !== 17'h10000) begin bad++; $display("FAIL reset_h: got %h want 10000", h); end
        total++; if (upd !== 1'b0) begin bad++; $display("FAIL reset_update: got %b want 0", upd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_next_commit();
        nxt = 1'b1; tick(); nxt = 1'b0;
        model_gen();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL next_busy: got %b want 1", busy); end
        repeat (ST) tick();
        total++; if (busy !== 1'b1 || upd !== 1'b0) begin bad++; $display("FAIL ready_wait: busy=%b upd=%b want 1/0", busy, upd); end
        total++; if (v !== e_v) begin bad++; $display("FAIL v_before_commit: got %h want %h", v, e_v); end
        frame = 1'b1; tick(); frame = 1'b0;
        e_v = m_v; e_h = m_h;
        total++; if (upd !== 1'b1) begin bad++; $display("FAIL commit_update: got %b want 1", upd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL commit_busy: got %b want 0", busy); end
        total++; if (v !== 30'h0000014C) begin bad++; $display("FAIL commit_v: got %h want 0000014c", v); end
        total++; if (h !== 17'h10004) begin bad++; $display("FAIL commit_h: got %h want 10004", h); end
        tick();
        total++; if (upd !== 1'b0) begin bad++; $display("FAIL update_width: got %b want 0", upd); end
    endtask

    task automatic test_ignored();
        int gap;
        nxt = 1'b1; tick(); nxt = 1'b0;
        model_gen();
        tick();
        nxt = 1'b1; tick(); nxt = 1'b0;
        frame = 1'b1; tick(); frame = 1'b0;
        total++; if (upd !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL gen_frame_ignored: upd=%b busy=%b want 0/1", upd, busy); end
        total++; if (v !== e_v || h !== e_h) begin bad++; $display("FAIL gen_frame_outputs: got %h/%h want %h/%h", v, h, e_v, e_h); end
        gap = $urandom_range(0, 5);
        for (int i = 0; i < gap; i++) begin
            tick();
            total++; if (upd !== 1'b0) begin bad++; $display("FAIL ready_no_update: got %b want 0", upd); end
        end
        frame = 1'b1; tick(); frame = 1'b0;
        e_v = m_v; e_h = m_h;
        total++; if (upd !== 1'b1) begin bad++; $display("FAIL ignored_commit: got %b want 1", upd); end
        total++; if (v !== e_v || h !== e_h) begin bad++; $display("FAIL ignored_values: got %h/%h want %h/%h", v, h, e_v, e_h); end
        repeat (ST + 2) tick();
        total++; if (busy !== 1'b0 || upd !== 1'b0) begin bad++; $display("FAIL next_not_queued: busy=%b upd=%b want 0/0", busy, upd); end
    endtask

    task automatic test_reset_mid_gen();
        nxt = 1'b1; tick(); nxt = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        total++; if (v !== VS || h !== HS) begin bad++; $display("FAIL midgen_seed: got %h/%h want %h/%h", v, h, VS, HS); end
        total++; if (busy !== 1'b0 || upd !== 1'b0) begin bad++; $display("FAIL midgen_flags: busy=%b upd=%b want 0/0", busy, upd); end
        frame = 1'b1; tick(); frame = 1'b0;
        total++; if (upd !== 1'b0) begin bad++; $display("FAIL midgen_discard: got %b want 0", upd); end
        nxt = 1'b1; tick(); nxt = 1'b0;
        model_gen();
        repeat (ST) tick();
        frame = 1'b1; tick(); frame = 1'b0;
        e_v = m_v; e_h = m_h;
        total++; if (upd !== 1'b1) begin bad++; $display("FAIL midgen_commit: got %b want 1", upd); end
        total++; if (v !== 30'h0000014C || h !== 17'h10004) begin bad++; $display("FAIL midgen_values: got %h/%h want 0000014c/10004", v, h); end
        tick();
    endtask

`ifdef HITOMEZASHI_AUTO_EN
    task automatic test_auto();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        model_reset();
        for (int k = 0; k < HF; k++) begin
            repeat (99) tick();
            frame = 1'b1; tick(); frame = 1'b0;
            if (k < HF - 1) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL auto_early: frame %0d busy=%b want 0", k, busy); end
            end else begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL auto_start: busy=%b want 1", busy); end
            end
        end
        model_gen();
        repeat (96) tick();
        total++; if (busy !== 1'b1 || upd !== 1'b0) begin bad++; $display("FAIL auto_ready: busy=%b upd=%b want 1/0", busy, upd); end
        frame = 1'b1; tick(); frame = 1'b0;
        e_v = m_v; e_h = m_h;
        total++; if (upd !== 1'b1) begin bad++; $display("FAIL auto_commit: got %b want 1", upd); end
        total++; if (v !== 30'h0000014C || h !== 17'h10004) begin bad++; $display("FAIL auto_values: got %h/%h want 0000014c/10004", v, h); end
        tick();
        total++; if (upd !== 1'b0) begin bad++; $display("FAIL auto_update_width: got %b want 0", upd); end
    endtask

    task automatic test_pause();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(2, 8)) tick();
            frame = 1'b1; tick(); frame = 1'b0;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL pause_hold: frame %0d busy=%b want 0", k, busy); end
        end
        nxt = 1'b1; tick(); nxt = 1'b0;
        model_gen();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL pause_next: busy=%b want 1", busy); end
        repeat (ST + $urandom_range(0, 4)) tick();
        frame = 1'b1; tick(); frame = 1'b0;
        e_v = m_v; e_h = m_h;
        total++; if (upd !== 1'b1 || v !== e_v || h !== e_h) begin bad++; $display("FAIL pause_commit: upd=%b %h/%h want 1 %h/%h", upd, v, h, e_v, e_h); end
        pause = 1'b0;
        tick();
    endtask

    task automatic test_next_frame_same();
        for (int k = 0; k < 2; k++) begin
            frame = 1'b1; tick(); frame = 1'b0; tick();
        end
        nxt = 1'b1; frame = 1'b1; tick(); nxt = 1'b0; frame = 1'b0;
        model_gen();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL same_cycle_gen: busy=%b want 1", busy); end
        repeat (ST) tick();
        frame = 1'b1; tick(); frame = 1'b0;
        e_v = m_v; e_h = m_h;
        total++; if (upd !== 1'b1 || v !== e_v || h !== e_h) begin bad++; $display("FAIL same_cycle_commit: upd=%b %h/%h want 1 %h/%h", upd, v, h, e_v, e_h); end
        for (int k = 0; k < HF; k++) begin
            tick(); frame = 1'b1; tick(); frame = 1'b0;
            total++; if (busy !== (k == HF - 1)) begin bad++; $display("FAIL count_restart: frame %0d busy=%b want %b", k, busy, k == HF - 1); end
        end
        model_gen();
        repeat (ST) tick();
        frame = 1'b1; tick(); frame = 1'b0;
        e_v = m_v; e_h = m_h;
        total++; if (upd !== 1'b1 || v !== e_v || h !== e_h) begin bad++; $display("FAIL recount_commit: upd=%b %h/%h want 1 %h/%h", upd, v, h, e_v, e_h); end
        tick();
    endtask
`else
    task automatic test_no_auto();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(1, 6)) tick();
            pause = 1'($urandom_range(0, 1));
            frame = 1'b1; tick(); frame = 1'b0;
            total++; if (upd !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL manual_hold: frame %0d upd=%b busy=%b want 0/0", k, upd, busy); end
        end
        pause = 1'b0;
        nxt = 1'b1; tick(); nxt = 1'b0;
        model_gen();
        repeat (ST) tick();
        frame = 1'b1; tick(); frame = 1'b0;
        e_v = m_v; e_h = m_h;
        total++; if (upd !== 1'b1) begin bad++; $display("FAIL manual_commit: got %b want 1", upd); end
        total++; if (v !== 30'h0000014C || h !== 17'h10004) begin bad++; $display("FAIL manual_values: got %h/%h want 0000014c/10004", v, h); end
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (upd !== 1'b0) begin bad++; $display("FAIL manual_single: cycle %0d upd=%b want 0", k, upd); end
        end
    endtask
`endif

    // Pattern-level model: requests start a ST-cycle generation, then a pattern waits for a frame.
    task automatic test_random();
        int gen_left = 0;
        bit pend = 1'b0;
        int fc = 0;
        bit f, n, p, start, exp_upd, exp_busy;
        for (int c = 0; c < 600; c++) begin
            f = ($urandom_range(0, 5) == 0);
            n = ($urandom_range(0, 11) == 0);
            p = ($urandom_range(0, 3) == 0);
            frame = f; nxt = n; pause = p;
            tick();
            exp_upd = 1'b0;
            start = 1'b0;
            if (gen_left > 0) begin
                gen_left--;
                if (gen_left == 0) pend = 1'b1;
            end else if (pend) begin
                if (f) begin
                    e_v = m_v; e_h = m_h;
                    exp_upd = 1'b1;
                    pend = 1'b0;
                    fc = 0;
                end
            end else if (n) begin
                start = 1'b1;
            end else begin
`ifdef HITOMEZASHI_AUTO_EN
                if (f && !p) begin
                    if (fc == HF - 1) start = 1'b1;
                    else fc++;
                end
`endif
            end
            if (start) begin
                gen_left = ST;
                fc = 0;
                model_gen();
            end
            exp_busy = (gen_left > 0) || pend;
            total++; if (upd !== exp_upd) begin bad++; $display("FAIL rand_update: cycle %0d got %b want %b", c, upd, exp_upd); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rand_busy: cycle %0d got %b want %b", c, busy, exp_busy); end
            total++; if (v !== e_v) begin bad++; $display("FAIL rand_v: cycle %0d got %h want %h", c, v, e_v); end
            total++; if (h !== e_h) begin bad++; $display("FAIL rand_h: cycle %0d got %h want %h", c, h, e_h); end
        end
        frame = 1'b0; nxt = 1'b0; pause = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_next_commit();
        test_ignored();
        test_reset_mid_gen();
`ifdef HITOMEZASHI_AUTO_EN
        test_auto();
        test_pause();
        test_next_frame_same();
`else
        test_no_auto();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
